fila_ctrl: RTL

// - Sequences the deserializer -> fila datapath in the clk_10KHz domain.
// - Syncs the deserializer's data_ready and the external dequeue_in into this domain.
// - Closes a 4-phase ready/ack handshake with the deserializer and arbitrates

---
 rtl/fila_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/fila_ctrl.sv
// Brings deserializer words into the clk_10KHz domain through a 4-phase ready/ack
// handshake, arbitrates enqueue vs dequeue strobes to fila and tracks its occupancy.
module fila_ctrl #(
  parameter  int WIDTH       = 8,
  parameter  int DEPTH       = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int LW          = $clog2(DEPTH + 1)
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic             data_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dequeue_in,
  output logic             ack_out,
  output logic             enqueue_out,
  output logic             dequeue_out,
  output logic [WIDTH-1:0] data_out,
  output logic [LW-1:0]    len_out,
  output logic             full_out,
  output logic             empty_out,
  output logic             underflow_err
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] rdy_sync, deq_sync;
  logic                   rdy_s, deq_s, deq_s_q, deq_rise;
  logic                   deq_pend, last_deq;
  logic                   enq_ok, deq_ok, grant_enq, grant_deq, drop, latch;

  assign rdy_s     = rdy_sync[SYNC_STAGES-1];
  assign deq_s     = deq_sync[SYNC_STAGES-1];
  assign deq_rise  = deq_s & ~deq_s_q;
  assign full_out  = (len_out == LW'(DEPTH));
  assign empty_out = (len_out == '0);

  always_comb begin
    enq_ok    = (state == REQ) && (len_out < LW'(DEPTH));
    deq_ok    = deq_pend && (len_out != '0);
    // Round robin on contention: last_deq=1 after reset hands the first tie to enqueue
    grant_enq = enq_ok && (!deq_ok || last_deq);
    grant_deq = deq_ok && !grant_enq;
    drop      = deq_pend && (len_out == '0) && (state != REQ);
    state_n   = state;
    latch     = 1'b0;
    case (state)
      IDLE: if (rdy_s && !full_out) begin
        state_n = REQ;
        latch   = 1'b1;
      end
      REQ:  if (grant_enq) state_n = ACK;
      ACK:  if (!rdy_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      rdy_sync      <= '0;
      deq_sync      <= '0;
      deq_s_q       <= 1'b0;
      state         <= IDLE;
      data_out      <= '0;
      ack_out       <= 1'b0;
      enqueue_out   <= 1'b0;
      dequeue_out   <= 1'b0;
      len_out       <= '0;
      deq_pend      <= 1'b0;
      last_deq      <= 1'b1;
      underflow_err <= 1'b0;
    end else begin
      rdy_sync    <= {rdy_sync[SYNC_STAGES-2:0], data_ready};
      deq_sync    <= {deq_sync[SYNC_STAGES-2:0], dequeue_in};
      deq_s_q     <= deq_s;
      state       <= state_n;
      if (latch) data_out <= data_in;
      ack_out     <= (state_n == ACK);
      enqueue_out <= grant_enq;
      dequeue_out <= grant_deq;
      if (grant_enq)      len_out <= len_out + LW'(1);
      else if (grant_deq) len_out <= len_out - LW'(1);
      if (grant_enq || grant_deq) last_deq <= grant_deq;
      // A rise while a request is already pending folds into it
      deq_pend    <= (deq_pend && !grant_deq && !drop) || (deq_rise && !deq_pend);
      if (drop) underflow_err <= 1'b1;
    end
  end

endmodule
